// File: rtl/pwm_ppm_pkg.sv
// Shared types for the PWM capture / PPM frame encoder.
// Holds the FSM encoding and the ChanIdx width helper.
package pwm_ppm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      PULSE,
      SPACE
   } state_t;

   function automatic int chan_w(input int n);
      return $clog2(n + 1);
   endfunction

   localparam int CHANNELS_DEF = 4;
   localparam int CHAN_W = chan_w(CHANNELS_DEF);

endpackage

// File: rtl/pwm_width_capture.sv
// One PWM channel: 2-flop synchroniser, fall detect,
// saturating high-time counter and captured width.
module pwm_width_capture #(
   parameter int CNT_W = 12
) (
   input  logic             ClkFast,
   input  logic             ResetN,
   input  logic             pwm,
   output logic [CNT_W-1:0] width
);

   logic             s1;
   logic             s2;
   logic             s3;
   logic             fall;
   logic [CNT_W-1:0] cnt;

   assign fall = s3 & ~s2;

   always_ff @(posedge ClkFast or negedge ResetN) begin
      if (!ResetN) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         s3    <= 1'b0;
         cnt   <= '0;
         width <= '0;
      end else begin
         s1 <= pwm;
         s2 <= s1;
         s3 <= s2;
         if (fall) begin
            width <= cnt;
            cnt   <= '0;
         end else if (s2 && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pwm_ppm_encoder.sv
// Multi-channel PWM width capture serialised into a PPM frame:
// sync gap, one marker per channel, then a terminating marker.
module pwm_ppm_encoder
   import pwm_ppm_pkg::*;
#(
   parameter int CHANNELS  = 4,
   parameter int CNT_W     = 12,
   parameter int PULSE_LEN = 8,
   parameter int GAP_MIN   = 2,
   parameter int SYNC_LEN  = 1024
) (
   input  logic                          ClkFast,
   input  logic                          ResetN,
   input  logic                          Enable,
   input  logic [CHANNELS-1:0]           PWMSIG,
   output logic                          PPMSIG,
   output logic                          FrameStart,
   output logic [chan_w(CHANNELS)-1:0]   ChanIdx,
   output logic                          Busy
);

   localparam int CW  = chan_w(CHANNELS);
   localparam int SW  = $clog2(SYNC_LEN + 1);
   localparam int PW  = $clog2(PULSE_LEN + 1);
   localparam int TW0 = (SW > CNT_W + 1) ? SW : CNT_W + 1;
   localparam int TW  = (PW > TW0) ? PW : TW0;

   logic [CNT_W-1:0] width [CHANNELS];
   logic [CNT_W-1:0] snap  [CHANNELS];
   logic [CNT_W-1:0] sel;

   state_t        state;
   state_t        state_n;
   logic [TW-1:0] tmr;
   logic [TW-1:0] tmr_n;
   logic [CW-1:0] idx;
   logic [CW-1:0] idx_n;
   logic          ppm_n;
   logic          fs_n;
   logic          take;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_cap
      pwm_width_capture #(
         .CNT_W(CNT_W)
      ) u_cap (
         .ClkFast(ClkFast),
         .ResetN (ResetN),
         .pwm    (PWMSIG[k]),
         .width  (width[k])
      );
   end

   always_comb begin
      sel = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (idx == CW'(k)) sel = snap[k];
      end
   end

   // tmr holds the cycles left in the current state after this one
   always_comb begin
      state_n = state;
      tmr_n   = tmr - 1'b1;
      idx_n   = idx;
      ppm_n   = PPMSIG;
      fs_n    = 1'b0;
      take    = 1'b0;
      unique case (state)
         IDLE: begin
            tmr_n = tmr;
            if (Enable) begin
               state_n = SYNC;
               tmr_n   = TW'(SYNC_LEN - 1);
            end
         end
         SYNC: begin
            if (tmr == '0) begin
               state_n = PULSE;
               tmr_n   = TW'(PULSE_LEN - 1);
               idx_n   = '0;
               ppm_n   = 1'b1;
               fs_n    = 1'b1;
               take    = 1'b1;
            end
         end
         PULSE: begin
            if (tmr == '0) begin
               ppm_n = 1'b0;
               if (idx < CW'(CHANNELS)) begin
                  state_n = SPACE;
                  tmr_n   = TW'(GAP_MIN - 1) + TW'(sel);
               end else begin
                  idx_n = '0;
                  if (Enable) begin
                     state_n = SYNC;
                     tmr_n   = TW'(SYNC_LEN - 1);
                  end else begin
                     state_n = IDLE;
                     tmr_n   = '0;
                  end
               end
            end
         end
         SPACE: begin
            if (tmr == '0) begin
               state_n = PULSE;
               tmr_n   = TW'(PULSE_LEN - 1);
               idx_n   = idx + 1'b1;
               ppm_n   = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge ClkFast or negedge ResetN) begin
      if (!ResetN) begin
         state      <= IDLE;
         tmr        <= '0;
         idx        <= '0;
         PPMSIG     <= 1'b0;
         FrameStart <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) snap[k] <= '0;
      end else begin
         state      <= state_n;
         tmr        <= tmr_n;
         idx        <= idx_n;
         PPMSIG     <= ppm_n;
         FrameStart <= fs_n;
         if (take) begin
            for (int k = 0; k < CHANNELS; k++) snap[k] <= width[k];
         end
      end
   end

   assign ChanIdx = idx;
   assign Busy    = (state != IDLE);

endmodule

// File: tb/tb_pwm_ppm_encoder.sv
// Directed bench for pwm_ppm_encoder: frame timing, snapshot,
// saturation, enable drop and mid-frame reset.
module tb_pwm_ppm_encoder;

   localparam int CH = 2;
   localparam int CW = 6;
   localparam int PL = 4;
   localparam int GM = 2;
   localparam int SL = 20;

   logic          ClkFast = 1'b0;
   logic          ResetN;
   logic          Enable;
   logic [CH-1:0] PWMSIG;
   logic          PPMSIG;
   logic          FrameStart;
   logic [1:0]    ChanIdx;
   logic          Busy;

   int checks   = 0;
   int failures = 0;
   int fs_seen  = 0;
   int acc      = 0;

   pwm_ppm_encoder #(
      .CHANNELS (CH),
      .CNT_W    (CW),
      .PULSE_LEN(PL),
      .GAP_MIN  (GM),
      .SYNC_LEN (SL)
   ) dut (
      .ClkFast   (ClkFast),
      .ResetN    (ResetN),
      .Enable    (Enable),
      .PWMSIG    (PWMSIG),
      .PPMSIG    (PPMSIG),
      .FrameStart(FrameStart),
      .ChanIdx   (ChanIdx),
      .Busy      (Busy)
   );

   always #5 ClkFast = ~ClkFast;

   always @(negedge ClkFast) begin
      if (FrameStart === 1'b1) fs_seen++;
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic run_len(input logic lvl, output int n);
      n = 0;
      while (PPMSIG === lvl && n < 300) begin
         n++;
         @(negedge ClkFast);
      end
      acc += n;
   endtask

   task automatic seg(input string tag, input logic lvl, input int exp);
      int n;
      run_len(lvl, n);
      chk(tag, n, exp);
   endtask

   task automatic marker(input string tag, input int ix, input int fs);
      chk({tag, "_idx"}, int'(ChanIdx), ix);
      chk({tag, "_fs"}, int'(FrameStart), fs);
      seg(tag, 1'b1, PL);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      ResetN = 1'b0;
      Enable = 1'b0;
      PWMSIG = '0;
      repeat (3) @(negedge ClkFast);
      ResetN = 1'b1;
      @(negedge ClkFast);
      chk("rst_ppm", PPMSIG, 0);
      chk("rst_fs", FrameStart, 0);
      chk("rst_idx", ChanIdx, 0);
      chk("rst_busy", Busy, 0);

      // ch0 high 10, ch1 high 5
      PWMSIG[0] = 1'b1;
      repeat (10) @(negedge ClkFast);
      PWMSIG[0] = 1'b0;
      PWMSIG[1] = 1'b1;
      repeat (5) @(negedge ClkFast);
      PWMSIG[1] = 1'b0;
      repeat (5) @(negedge ClkFast);

      Enable = 1'b1;
      @(negedge ClkFast);
      chk("en_busy", Busy, 1);
      seg("b_sync", 1'b0, 20);
      marker("b_m0", 0, 1);
      seg("b_sp0", 1'b0, 12);
      marker("b_m1", 1, 0);
      seg("b_sp1", 1'b0, 7);
      marker("b_end", 2, 0);

      // second frame, enable dropped in ch0 space
      seg("r_sync", 1'b0, 20);
      marker("r_m0", 0, 1);
      Enable = 1'b0;
      seg("d_sp0", 1'b0, 12);
      marker("d_m1", 1, 0);
      seg("d_sp1", 1'b0, 7);
      marker("d_end", 2, 0);
      chk("d_busy", Busy, 0);
      n = 0;
      repeat (30) begin
         if (PPMSIG !== 1'b0) n++;
         @(negedge ClkFast);
      end
      chk("d_idle_hi", n, 0);

      // ch1 recaptured (9) on the FrameStart edge
      Enable = 1'b1;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge ClkFast);
         if (i == 9) PWMSIG[1] = 1'b1;
         if (i == 18) PWMSIG[1] = 1'b0;
         if (PPMSIG === 1'b0) n++;
      end
      chk("s_sync", n, 20);
      @(negedge ClkFast);
      marker("s_m0", 0, 1);
      seg("s_sp0", 1'b0, 12);
      marker("s_m1", 1, 0);
      seg("s_sp1_old", 1'b0, 7);
      marker("s_end", 2, 0);
      seg("s2_sync", 1'b0, 20);
      marker("s2_m0", 0, 1);
      seg("s2_sp0", 1'b0, 12);
      marker("s2_m1", 1, 0);
      seg("s2_sp1_new", 1'b0, 11);
      marker("s2_end", 2, 0);

      // reset in the middle of a marker
      seg("x_sync", 1'b0, 20);
      @(negedge ClkFast);
      ResetN = 1'b0;
      #1;
      chk("x_ppm", PPMSIG, 0);
      chk("x_busy", Busy, 0);
      chk("x_idx", ChanIdx, 0);
      repeat (2) @(negedge ClkFast);
      ResetN = 1'b1;
      @(negedge ClkFast);
      chk("u_busy", Busy, 1);
      acc = 0;
      seg("u_sync", 1'b0, 20);
      marker("u_m0", 0, 1);
      Enable = 1'b0;
      seg("u_sp0", 1'b0, 2);
      marker("u_m1", 1, 0);
      seg("u_sp1", 1'b0, 2);
      marker("u_end", 2, 0);
      chk("u_frame", acc, 36);
      chk("u_idle", Busy, 0);

      // ch0 held past saturation
      PWMSIG[0] = 1'b1;
      repeat (100) @(negedge ClkFast);
      PWMSIG[0] = 1'b0;
      repeat (5) @(negedge ClkFast);
      Enable = 1'b1;
      @(negedge ClkFast);
      seg("t_sync", 1'b0, 20);
      marker("t_m0", 0, 1);
      Enable = 1'b0;
      seg("t_sp0_sat", 1'b0, 65);
      marker("t_m1", 1, 0);
      seg("t_sp1", 1'b0, 2);
      marker("t_end", 2, 0);
      chk("t_idle", Busy, 0);

      @(negedge ClkFast);
      chk("fs_count", fs_seen, 7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pwm_ppm_encoder.md
# pwm_ppm_encoder

Multi-channel successor to the single-channel PWM-to-PPM converter. Measures the high time of `CHANNELS` asynchronous PWM inputs in `ClkFast` cycles and serialises the measured widths into one standard PPM frame stream: a sync gap, then one marker pulse per channel, then a terminating pulse. The block sits between the PWM capture pins and the PPM output driver. All logic runs on `ClkFast`; the inputs need no separate slow clock.

## Interface
- `CHANNELS`, 4: number of PWM inputs, 1..16.
- `CNT_W`, 12: width of the width counters; measured values saturate at 2^CNT_W-1.
- `PULSE_LEN`, 8: PPM marker pulse length in cycles, ≥1.
- `GAP_MIN`, 2: fixed low time added after each marker, ≥1.
- `SYNC_LEN`, 1024: frame sync low time in cycles, ≥1.

Ports:
- `ClkFast` input 1: the single clock.
- `ResetN` input 1: reset, asynchronous and active-low.
- `Enable` input 1: allows frames to be generated.
- `PWMSIG` input CHANNELS: asynchronous PWM inputs, bit k = channel k.
- `PPMSIG` output 1: PPM stream.
- `FrameStart` output 1: one-cycle strobe at the first marker of each frame.
- `ChanIdx` output $clog2(CHANNELS+1): index of the current marker/space.
- `Busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- **Synchroniser:** each `PWMSIG` bit passes through 2 flops, then a third flop provides edge detection.
- **Width counter, per channel:** counts cycles while the synchronised input is high, saturating at max.
  - On a synchronised falling edge: `width[k]` ← count and the counter clears.
  - If the input is still high at saturation, the saturated value is latched on the eventual fall.
  - A channel that never falls keeps `width[k]=0`.
- **Snapshot:** all `width[k]` are copied into `snap[k]` on the cycle `FrameStart` is asserted. Captures landing in the same cycle are not included in the snapshot; they are used in the next frame.
- **FSM states:**
  - IDLE: `PPMSIG`=0. Goes to SYNC when `Enable`=1.
  - SYNC: `PPMSIG`=0 for `SYNC_LEN` cycles, then PULSE with `ChanIdx`=0, `FrameStart`=1 and the snapshot taken.
  - PULSE: `PPMSIG`=1 for `PULSE_LEN` cycles. If `ChanIdx`<CHANNELS, go to SPACE; otherwise this is the terminating pulse, so go to SYNC if `Enable`=1, else IDLE.
  - SPACE: `PPMSIG`=0 for `GAP_MIN`+`snap[ChanIdx]` cycles, then `ChanIdx`++ and PULSE.
- **Arithmetic:** the space counter is CNT_W+1 bits wide; no overflow is possible.
- **Enable deasserted mid-frame:** the current frame completes, including the terminating pulse, and then the FSM goes to IDLE. `Enable` is sampled only at the end of the terminating pulse and in IDLE.
- **Reset at any time:** clears all state immediately, and any partial frame is truncated.

## Timing
- **Reset values:**
  - Outputs: `PPMSIG`=0, `FrameStart`=0, `ChanIdx`=0, `Busy`=0.
  - Internal: all sync flops, counters, `width` and `snap` are 0; FSM is IDLE.
- **Capture latency:** `width[k]` updates 3 cycles after a raw falling edge that meets setup. The recorded value is the number of cycles the synchronised signal was high.
- **Enable to output:** `Enable` high in IDLE gives `Busy`=1 on the next cycle, followed by `SYNC_LEN` low cycles before the first marker.
- **Frame length:** SYNC_LEN + (CHANNELS+1)·PULSE_LEN + Σ(GAP_MIN+snap[k]) cycles.
- **Marker spacing:** the leading-edge spacing between marker k and marker k+1 is PULSE_LEN+GAP_MIN+snap[k].
- **Registered outputs:** `PPMSIG`, `FrameStart` and `ChanIdx` all come from flops, and change together on the state-transition edge.

## Structure
- **Shared package `pwm_ppm_pkg`:**
  - FSM state encoding: IDLE, SYNC, PULSE, SPACE.
  - Localparam for the `ChanIdx` width.
- **Sub-module `pwm_width_capture`** (synchroniser, edge detect, saturating counter, `width` register), instantiated `CHANNELS` times with a generate loop.
- **Top level:** snapshot registers, channel mux and FSM.

## Test plan
Common parameters: CHANNELS=2, CNT_W=6, PULSE_LEN=4, GAP_MIN=2, SYNC_LEN=20.
- **Basic frame:** ch0 high 10 cycles, ch1 high 5, then `Enable`=1 → 20 low, 4 high, 12 low, 4 high, 7 low, 4 high, then repeat. `FrameStart` pulses once per frame.
- **Unseen channels:** no PWM activity, `Enable`=1 → spaces of 2 cycles. Frame length = 20+12+4 = 36.
- **Saturation:** ch0 held high 100 cycles then released → `width[0]`=63, so the ch0 space is 65 cycles.
- **Snapshot rule:** ch1 falling edge captured in the same cycle as `FrameStart` (old width 5, new width 9) → this frame's ch1 space is 7 and the next frame's is 11.
- **Enable drop:** `Enable` drops during ch0 SPACE → the frame finishes through the terminating pulse, then `PPMSIG`=0 and `Busy`=0.
- **Reset mid-operation:** `ResetN` low during PULSE → `PPMSIG`=0 immediately; all widths read 0 after release; the frame restarts with a full SYNC.
